// File: rtl/param_updown_counter_if.sv
// Control/status bundle for param_updown_counter: the driver uses the master
// modport, the counter uses the slave modport.
interface param_updown_counter_if #(
    parameter int WIDTH = 16
);
    logic             en;
    logic             UpOrDown;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             clr_flags;
    logic [WIDTH-1:0] Count;
    logic             tc;
    logic             ovf;
    logic             udf;

    modport master (
        output en, UpOrDown, load, load_val, clr_flags,
        input  Count, tc, ovf, udf
    );

    modport slave (
        input  en, UpOrDown, load, load_val, clr_flags,
        output Count, tc, ovf, udf
    );
endinterface

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with modulo limit, wrap/saturate, prescaled enable,
// synchronous load, registered terminal-count pulse and sticky ovf/udf flags.
module param_updown_counter #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter bit               SAT_MODE = 1'b0,
    parameter int               PRESCALE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    param_updown_counter_if.slave bus
);
    localparam int PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [WIDTH-1:0] count_q, count_d;
    logic [PCW-1:0]   pcnt_q, pcnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             tick, at_top, at_bot, set_ovf, set_udf;

    assign at_top  = (count_q == MAX_VAL);
    assign at_bot  = (count_q == '0);
    assign tick    = bus.en & ~bus.load & (pcnt_q == PCW'(PRESCALE - 1));
    assign set_ovf = tick &  bus.UpOrDown & at_top;
    assign set_udf = tick & ~bus.UpOrDown & at_bot;

    always_comb begin
        count_d = count_q;
        pcnt_d  = pcnt_q;
        tc_d    = 1'b0;
        if (bus.load) begin
            count_d = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
            pcnt_d  = '0;
        end else if (bus.en) begin
            pcnt_d = tick ? '0 : pcnt_q + PCW'(1);
            if (tick) begin
                // Limits are explicit compares so MAX_VAL below 2^WIDTH-1 wraps correctly
                if (bus.UpOrDown) begin
                    if (at_top) begin
                        count_d = SAT_MODE ? MAX_VAL : '0;
                        tc_d    = 1'b1;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end else begin
                    if (at_bot) begin
                        count_d = SAT_MODE ? '0 : MAX_VAL;
                        tc_d    = 1'b1;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end
        end
    end

    // A set event outranks a same-cycle clear
    assign ovf_d = set_ovf | (ovf_q & ~bus.clr_flags);
    assign udf_d = set_udf | (udf_q & ~bus.clr_flags);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            pcnt_q  <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            pcnt_q  <= pcnt_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign bus.Count = count_q;
    assign bus.tc    = tc_q;
    assign bus.ovf   = ovf_q;
    assign bus.udf   = udf_q;
endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench: three counter instances (wrap, saturate, prescale-by-3), WIDTH=4, MAX_VAL=9.
module tb_param_updown_counter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    param_updown_counter_if #(.WIDTH(4)) ia ();
    param_updown_counter_if #(.WIDTH(4)) ib ();
    param_updown_counter_if #(.WIDTH(4)) ic ();

    param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SAT_MODE(1'b0), .PRESCALE(1))
        u_wrap (.clk(clk), .reset(reset), .bus(ia));
    param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SAT_MODE(1'b1), .PRESCALE(1))
        u_sat  (.clk(clk), .reset(reset), .bus(ib));
    param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SAT_MODE(1'b0), .PRESCALE(3))
        u_pre  (.clk(clk), .reset(reset), .bus(ic));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input int c, input bit t, input bit o, input bit u);
        chk({tag, ".cnt"}, 32'(ia.Count), 32'(c));
        chk({tag, ".tc"},  32'(ia.tc),    32'(t));
        chk({tag, ".ovf"}, 32'(ia.ovf),   32'(o));
        chk({tag, ".udf"}, 32'(ia.udf),   32'(u));
    endtask

    task automatic chk_b(input string tag, input int c, input bit t, input bit o, input bit u);
        chk({tag, ".cnt"}, 32'(ib.Count), 32'(c));
        chk({tag, ".tc"},  32'(ib.tc),    32'(t));
        chk({tag, ".ovf"}, 32'(ib.ovf),   32'(o));
        chk({tag, ".udf"}, 32'(ib.udf),   32'(u));
    endtask

    initial begin
        {ia.en, ia.UpOrDown, ia.load, ia.clr_flags} = '0; ia.load_val = '0;
        {ib.en, ib.UpOrDown, ib.load, ib.clr_flags} = '0; ib.load_val = '0;
        {ic.en, ic.UpOrDown, ic.load, ic.clr_flags} = '0; ic.load_val = '0;

        #12;
        chk_a("rst", 0, 0, 0, 0);
        chk("rst.pre.cnt", 32'(ic.Count), 32'd0);

        // Wrap up on the wrap instance
        ia.en = 1'b1; ia.UpOrDown = 1'b1;
        @(negedge clk); reset = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk($sformatf("up%0d.cnt", i), 32'(ia.Count), 32'(i));
            chk($sformatf("up%0d.tc", i),  32'(ia.tc),    32'd0);
        end
        step(); chk_a("wrap9to0", 0, 1, 1, 0);
        step(); chk_a("after_wrap", 1, 0, 1, 0);

        // Asynchronous reset mid-count at Count=5
        for (int i = 0; i < 4; i++) step();
        chk("pre_rst.cnt", 32'(ia.Count), 32'd5);
        #2 reset = 1'b0;
        #1 chk_a("async_rst", 0, 0, 0, 0);
        @(negedge clk); reset = 1'b1;
        step(); chk_a("resume", 1, 0, 0, 0);

        // Flags: clear alone, then clear coinciding with a set
        ia.load = 1'b1; ia.load_val = 4'd9;
        step(); chk_a("ld9", 9, 0, 0, 0);
        ia.load = 1'b0;
        step(); chk_a("ovf_set", 0, 1, 1, 0);
        ia.en = 1'b0; ia.clr_flags = 1'b1;
        step(); chk_a("clr_alone", 0, 0, 0, 0);
        ia.clr_flags = 1'b0; ia.load = 1'b1;
        step(); chk_a("ld9b", 9, 0, 0, 0);
        ia.load = 1'b0; ia.en = 1'b1; ia.clr_flags = 1'b1;
        step(); chk_a("clr_vs_set", 0, 1, 1, 0);
        ia.clr_flags = 1'b0;

        // Wrap down
        ia.load = 1'b1; ia.load_val = 4'd0;
        step(); chk_a("ld0", 0, 0, 1, 0);
        ia.load = 1'b0; ia.UpOrDown = 1'b0;
        step(); chk_a("wrap0to9", 9, 1, 1, 1);
        step(); chk_a("dn8", 8, 0, 1, 1);
        step(); chk_a("dn7", 7, 0, 1, 1);
        ia.load = 1'b1; ia.load_val = 4'd12;
        step(); chk_a("clamp", 9, 0, 1, 1);
        ia.load = 1'b0; ia.en = 1'b0;

        // Saturate instance
        ib.en = 1'b1; ib.UpOrDown = 1'b1; ib.load = 1'b1; ib.load_val = 4'd8;
        step(); chk_b("s.ld8", 8, 0, 0, 0);
        ib.load = 1'b0;
        step(); chk_b("s.up9", 9, 0, 0, 0);
        step(); chk_b("s.pin1", 9, 1, 1, 0);
        step(); chk_b("s.pin2", 9, 1, 1, 0);
        ib.load = 1'b1; ib.load_val = 4'd1;
        step(); chk_b("s.ld1", 1, 0, 1, 0);
        ib.load = 1'b0; ib.UpOrDown = 1'b0;
        step(); chk_b("s.dn0", 0, 0, 1, 0);
        step(); chk_b("s.pin0a", 0, 1, 1, 1);
        step(); chk_b("s.pin0b", 0, 1, 1, 1);
        ib.en = 1'b0;
        step(); chk_b("s.hold", 0, 0, 1, 1);

        // Prescale-by-3 instance
        ic.en = 1'b1; ic.UpOrDown = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk($sformatf("p.c%0d", i), 32'(ic.Count), 32'(i / 3));
        end
        ic.en = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("p.hold", 32'(ic.Count), 32'd3);
        ic.en = 1'b1;
        step(); step();
        chk("p.mid", 32'(ic.Count), 32'd3);
        ic.UpOrDown = 1'b0;
        step(); chk("p.dir", 32'(ic.Count), 32'd2);
        step();
        ic.load = 1'b1; ic.load_val = 4'd12;
        step(); chk("p.clamp", 32'(ic.Count), 32'd9);
        ic.load = 1'b0; ic.UpOrDown = 1'b1;
        step(); step();
        chk("p.pc_rst.cnt", 32'(ic.Count), 32'd9);
        chk("p.pc_rst.tc",  32'(ic.tc),    32'd0);
        step();
        chk("p.wrap.cnt", 32'(ic.Count), 32'd0);
        chk("p.wrap.tc",  32'(ic.tc),    32'd1);
        chk("p.wrap.ovf", 32'(ic.ovf),   32'd1);
        step();
        chk("p.tc_off", 32'(ic.tc), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
